// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC delay sensor: FSM state encoding,
// a constant-safe width helper and the default inverter count per tap.
package tdc_pkg;

    localparam int INV_PER_TAP_DEF = 12;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_CAPT   = 3'd2,
        ST_SYNC   = 3'd3,
        ST_ENC    = 3'd4,
        ST_ACC    = 3'd5,
        ST_DONE   = 3'd6
    } tdc_state_e;

    // Bits needed to hold values 0..value-1; never returns less than 1.
    function automatic int tdc_clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/tdc_tap.sv
// One delay tap: an even-length chain of kept inverters, so q follows a
// with identical polarity after INV_PER_TAP gate delays.
module tdc_tap
    import tdc_pkg::*;
#(
    parameter int INV_PER_TAP = INV_PER_TAP_DEF
) (
    input  logic a,
    output logic q
);

    (* keep = "true" *) logic [INV_PER_TAP:0] node_w;

    assign node_w[0] = a;

    for (genvar i = 0; i < INV_PER_TAP; i++) begin : g_cinv
        assign node_w[i+1] = ~node_w[i];
    end

    assign q = node_w[INV_PER_TAP];

endmodule

// File: rtl/tdc_sensor_ctrl.sv
// Self-timed TDC delay sensor: launch flop into a kept delay line, one-period
// capture, resync, bubble-tolerant encoder and 2^k sample averaging.
//
// state  | meaning
// IDLE   | waiting for en & start
// LAUNCH | toggle launch flop, record new polarity
// CAPT   | sample tap outputs one clk after the launch edge
// SYNC   | second resync stage
// ENC    | polarity-normalise and encode first-zero index
// ACC    | accumulate count, update range flags and sample counter
// DONE   | publish averaged result, restart or return to IDLE
module tdc_sensor_ctrl
    import tdc_pkg::*;
#(
    parameter  int N_TAPS       = 32,
    parameter  int INV_PER_TAP  = INV_PER_TAP_DEF,
    parameter  int AVG_MAX_LOG2 = 4,
    localparam int CNT_W        = tdc_clog2(N_TAPS + 1),
    localparam int SUM_W        = CNT_W + AVG_MAX_LOG2,
    localparam int AVG_W        = tdc_clog2(AVG_MAX_LOG2 + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              start,
    input  logic              cfg_cont,
    input  logic [AVG_W-1:0]  cfg_avg,
    output logic              busy,
    output logic [CNT_W-1:0]  result,
    output logic              result_valid,
    output logic [N_TAPS-1:0] raw_snap,
    output logic              ovf,
    output logic              unf
);

    localparam int SMP_W = AVG_MAX_LOG2 + 1;

    tdc_state_e        state_q;
    logic              launch_q;
    logic              pol_q;
    logic [N_TAPS-1:0] snap1_q;
    logic [N_TAPS-1:0] snap2_q;
    logic [N_TAPS-1:0] raw_snap_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [SUM_W-1:0]  acc_q;
    logic [SMP_W-1:0]  smp_q;
    logic [AVG_W-1:0]  k_q;
    logic [CNT_W-1:0]  result_q;
    logic              result_valid_q;
    logic              busy_q;
    logic              ovf_q;
    logic              unf_q;

    logic [N_TAPS-1:0] norm_w;
    logic [CNT_W-1:0]  cnt_d;
    logic [AVG_W-1:0]  k_in_w;
    logic [SMP_W-1:0]  smp_d;
    logic              last_smp_w;

    // Delay line: every tap output carries the launch polarity once reached.
    (* keep = "true" *) logic [N_TAPS:0]   chain_w;
    (* keep = "true" *) logic [N_TAPS-1:0] tap_w;

    assign chain_w[0] = launch_q;

    for (genvar t = 0; t < N_TAPS; t++) begin : g_tap
        (* keep = "true" *) tdc_tap #(
            .INV_PER_TAP(INV_PER_TAP)
        ) u_tap (
            .a(chain_w[t]),
            .q(chain_w[t+1])
        );
    end

    assign tap_w = chain_w[N_TAPS:1];

    assign k_in_w = (cfg_avg > AVG_W'(AVG_MAX_LOG2)) ? AVG_W'(AVG_MAX_LOG2) : cfg_avg;

    assign smp_d      = smp_q + SMP_W'(1);
    assign last_smp_w = (smp_d == (SMP_W'(1) << k_q));

    // First zero from bit 0 wins, so bubbles higher up the line are ignored.
    always_comb begin
        norm_w = pol_q ? snap2_q : ~snap2_q;
        cnt_d  = CNT_W'(N_TAPS);
        for (int i = N_TAPS - 1; i >= 0; i--) begin
            if (!norm_w[i]) begin
                cnt_d = CNT_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            launch_q       <= 1'b0;
            pol_q          <= 1'b0;
            snap1_q        <= '0;
            snap2_q        <= '0;
            raw_snap_q     <= '0;
            cnt_q          <= '0;
            acc_q          <= '0;
            smp_q          <= '0;
            k_q            <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            ovf_q          <= 1'b0;
            unf_q          <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            if (!en) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            state_q <= ST_LAUNCH;
                            busy_q  <= 1'b1;
                            acc_q   <= '0;
                            smp_q   <= '0;
                            ovf_q   <= 1'b0;
                            unf_q   <= 1'b0;
                            k_q     <= k_in_w;
                        end
                    end
                    ST_LAUNCH: begin
                        launch_q <= ~launch_q;
                        pol_q    <= ~launch_q;
                        state_q  <= ST_CAPT;
                    end
                    ST_CAPT: begin
                        snap1_q <= tap_w;
                        state_q <= ST_SYNC;
                    end
                    ST_SYNC: begin
                        snap2_q <= snap1_q;
                        state_q <= ST_ENC;
                    end
                    ST_ENC: begin
                        raw_snap_q <= norm_w;
                        cnt_q      <= cnt_d;
                        state_q    <= ST_ACC;
                    end
                    ST_ACC: begin
                        acc_q   <= acc_q + SUM_W'(cnt_q);
                        ovf_q   <= ovf_q | (cnt_q == CNT_W'(N_TAPS));
                        unf_q   <= unf_q | (cnt_q == '0);
                        smp_q   <= smp_d;
                        state_q <= last_smp_w ? ST_DONE : ST_LAUNCH;
                    end
                    ST_DONE: begin
                        result_q       <= CNT_W'(acc_q >> k_q);
                        result_valid_q <= 1'b1;
                        if (cfg_cont) begin
                            state_q <= ST_LAUNCH;
                            acc_q   <= '0;
                            smp_q   <= '0;
                            ovf_q   <= 1'b0;
                            unf_q   <= 1'b0;
                            k_q     <= k_in_w;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign raw_snap     = raw_snap_q;
    assign ovf          = ovf_q;
    assign unf          = unf_q;

endmodule

// File: tb/tb_tdc_sensor_ctrl.sv
// Scoreboard bench for tdc_sensor_ctrl; the delay line is emulated by forcing
// the tap vector to a reached-tap mask that follows the launch level.
module tb_tdc_sensor_ctrl;

    localparam int N_TAPS       = 32;
    localparam int AVG_MAX_LOG2 = 4;
    localparam int CNT_W        = 6;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic              start;
    logic              cfg_cont;
    logic [2:0]        cfg_avg;
    logic              busy;
    logic [CNT_W-1:0]  result;
    logic              result_valid;
    logic [N_TAPS-1:0] raw_snap;
    logic              ovf;
    logic              unf;

    typedef struct {
        logic [CNT_W-1:0]  res;
        logic              ovf;
        logic              unf;
        logic [N_TAPS-1:0] raw;
        int                cyc;
    } exp_t;

    exp_t sb_q[$];

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic mdl_launch = 1'b0;
    bit   emu_on = 1'b0;
    bit   forced = 1'b0;
    logic [N_TAPS-1:0] mask_a = '0;
    logic [N_TAPS-1:0] mask_b = '0;

    tdc_sensor_ctrl #(
        .N_TAPS(N_TAPS),
        .INV_PER_TAP(12),
        .AVG_MAX_LOG2(AVG_MAX_LOG2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .start(start),
        .cfg_cont(cfg_cont),
        .cfg_avg(cfg_avg),
        .busy(busy),
        .result(result),
        .result_valid(result_valid),
        .raw_snap(raw_snap),
        .ovf(ovf),
        .unf(unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reached taps show the new launch level, unreached ones the old level.
    always @(negedge clk) begin
        if (emu_on) begin
            force dut.tap_w = dut.launch_q ? mask_a : ~mask_b;
            forced = 1'b1;
        end
    end

    function automatic int lead_ones(input logic [N_TAPS-1:0] v);
        int n;
        n = 0;
        while (n < N_TAPS && v[n]) n++;
        return n;
    endfunction

    task automatic run_meas(input string name, input int k_cfg,
                            input logic [N_TAPS-1:0] ma, input logic [N_TAPS-1:0] mb,
                            input bit emu, input bit extra_start);
        exp_t e;
        exp_t g;
        int k_eff, nsmp, sum, c;
        logic lvl;
        logic [N_TAPS-1:0] norm;
        bit seen;
        k_eff = (k_cfg > AVG_MAX_LOG2) ? AVG_MAX_LOG2 : k_cfg;
        nsmp  = 1 << k_eff;
        lvl   = mdl_launch;
        sum   = 0;
        e.ovf = 1'b0;
        e.unf = 1'b0;
        e.raw = '0;
        for (int j = 0; j < nsmp; j++) begin
            lvl  = ~lvl;
            norm = lvl ? ma : mb;
            c    = lead_ones(norm);
            sum += c;
            if (c == N_TAPS) e.ovf = 1'b1;
            if (c == 0) e.unf = 1'b1;
            e.raw = norm;
        end
        e.res  = CNT_W'(sum >> k_eff);
        mask_a = ma;
        mask_b = mb;
        if (emu) begin
            emu_on = 1'b1;
        end else begin
            emu_on = 1'b0;
            if (forced) release dut.tap_w;
            forced = 1'b0;
        end
        cfg_avg = 3'(k_cfg);
        @(negedge clk);
        start = 1'b1;
        e.cyc = cyc + 1 + 5 * nsmp + 1;
        sb_q.push_back(e);
        @(negedge clk);
        start   = 1'b0;
        cfg_avg = 3'd0;
        seen    = 1'b0;
        for (int t = 0; t < 5 * nsmp + 20 && !seen; t++) begin
            start = (extra_start && t == 2);
            if (result_valid) begin
                seen = 1'b1;
                g = sb_q.pop_front();
                n_chk++;
                if (result !== g.res) begin
                    n_err++;
                    $display("FAIL %s result: got %0d want %0d", name, result, g.res);
                end
                n_chk++;
                if (ovf !== g.ovf) begin
                    n_err++;
                    $display("FAIL %s ovf: got %b want %b", name, ovf, g.ovf);
                end
                n_chk++;
                if (unf !== g.unf) begin
                    n_err++;
                    $display("FAIL %s unf: got %b want %b", name, unf, g.unf);
                end
                n_chk++;
                if (raw_snap !== g.raw) begin
                    n_err++;
                    $display("FAIL %s raw_snap: got %h want %h", name, raw_snap, g.raw);
                end
                n_chk++;
                if (cyc !== g.cyc) begin
                    n_err++;
                    $display("FAIL %s valid_cycle: got %0d want %0d", name, cyc, g.cyc);
                end
            end
            if (!seen) @(negedge clk);
        end
        start = 1'b0;
        n_chk++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s timeout: got no result_valid want one pulse", name);
            sb_q.delete();
        end
        mdl_launch = lvl;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s after_done: got busy=%b valid=%b want 0 0", name, busy, result_valid);
        end
        n_chk++;
        if (dut.launch_q !== mdl_launch) begin
            n_err++;
            $display("FAIL %s launch_level: got %b want %b", name, dut.launch_q, mdl_launch);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; start = 1'b0; cfg_cont = 1'b0; cfg_avg = 3'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b want 0", busy); end
        n_chk++;
        if (result !== '0) begin n_err++; $display("FAIL reset result: got %0d want 0", result); end
        n_chk++;
        if (result_valid !== 1'b0) begin n_err++; $display("FAIL reset valid: got %b want 0", result_valid); end
        n_chk++;
        if (raw_snap !== '0) begin n_err++; $display("FAIL reset raw_snap: got %h want 0", raw_snap); end
        n_chk++;
        if (ovf !== 1'b0 || unf !== 1'b0) begin
            n_err++; $display("FAIL reset flags: got ovf=%b unf=%b want 0 0", ovf, unf);
        end
        n_chk++;
        if (dut.launch_q !== 1'b0) begin n_err++; $display("FAIL reset launch: got %b want 0", dut.launch_q); end
    endtask

    task automatic test_single();
        run_meas("single_mid", 0, 32'h0000FFFF, 32'h0000FFFF, 1'b1, 1'b0);
    endtask

    task automatic test_avg8();
        run_meas("avg8_mid", 3, 32'h0000FFFF, 32'h0000FFFF, 1'b1, 1'b0);
    endtask

    task automatic test_ovf();
        run_meas("ovf_short_line", 1, '1, '1, 1'b0, 1'b0);
    endtask

    task automatic test_unf();
        run_meas("unf_long_line", 0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_bubble();
        run_meas("bubble", 0, 32'h0000F7FF, 32'h0000F7FF, 1'b1, 1'b0);
    endtask

    task automatic test_truncate();
        run_meas("avg2_truncate", 1, 32'h0000001F, 32'h0000003F, 1'b1, 1'b0);
    endtask

    task automatic test_clamp();
        run_meas("avg_clamp", 7, 32'h00000007, 32'h0000000F, 1'b1, 1'b0);
    endtask

    task automatic test_start_busy();
        run_meas("start_while_busy", 0, 32'h0000FFFF, 32'h0000FFFF, 1'b1, 1'b1);
    endtask

    task automatic test_cont_en_drop();
        exp_t e;
        exp_t g;
        int st, got, spurious;
        mask_a = 32'h000000FF; mask_b = 32'h000000FF; emu_on = 1'b1;
        cfg_cont = 1'b1; cfg_avg = 3'd0;
        @(negedge clk);
        start = 1'b1;
        st = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            e.res = CNT_W'(8); e.ovf = 1'b0; e.unf = 1'b0; e.raw = 32'h000000FF;
            e.cyc = st + 6 * (i + 1);
            sb_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        got = 0;
        for (int t = 0; t < 80 && got < 3; t++) begin
            if (result_valid) begin
                g = sb_q.pop_front();
                got++;
                n_chk++;
                if (result !== g.res || raw_snap !== g.raw || ovf !== g.ovf || unf !== g.unf) begin
                    n_err++;
                    $display("FAIL cont pulse%0d data: got res=%0d raw=%h ovf=%b unf=%b want res=%0d raw=%h 0 0",
                             got, result, raw_snap, ovf, unf, g.res, g.raw);
                end
                n_chk++;
                if (cyc !== g.cyc) begin
                    n_err++;
                    $display("FAIL cont pulse%0d cycle: got %0d want %0d", got, cyc, g.cyc);
                end
            end
            if (got < 3) @(negedge clk);
        end
        n_chk++;
        if (got != 3) begin
            n_err++;
            $display("FAIL cont timeout: got %0d pulses want 3", got);
            sb_q.delete();
        end
        repeat (2) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL en_drop busy: got %b want 0", busy); end
        spurious = 0;
        for (int t = 0; t < 30; t++) begin
            if (result_valid) spurious++;
            @(negedge clk);
        end
        n_chk++;
        if (spurious != 0) begin n_err++; $display("FAIL en_drop pulses: got %0d want 0", spurious); end
        n_chk++;
        if (result !== CNT_W'(8)) begin n_err++; $display("FAIL en_drop result_hold: got %0d want 8", result); end
        cfg_cont = 1'b0;
        en = 1'b1;
    endtask

    task automatic test_async_reset();
        mask_a = 32'h000000FF; mask_b = 32'h000000FF; emu_on = 1'b1;
        cfg_avg = 3'd0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            n_err++; $display("FAIL arst busy_valid: got %b %b want 0 0", busy, result_valid);
        end
        n_chk++;
        if (result !== '0) begin n_err++; $display("FAIL arst result: got %0d want 0", result); end
        n_chk++;
        if (raw_snap !== '0) begin n_err++; $display("FAIL arst raw_snap: got %h want 0", raw_snap); end
        n_chk++;
        if (ovf !== 1'b0 || unf !== 1'b0) begin
            n_err++; $display("FAIL arst flags: got ovf=%b unf=%b want 0 0", ovf, unf);
        end
        n_chk++;
        if (dut.launch_q !== 1'b0) begin n_err++; $display("FAIL arst launch: got %b want 0", dut.launch_q); end
        @(negedge clk);
        rst_n = 1'b1;
        mdl_launch = 1'b0;
        sb_q.delete();
        @(negedge clk);
        run_meas("after_reset", 0, 32'h0000FFFF, 32'h0000FFFF, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_avg8();
        test_ovf();
        test_unf();
        test_bubble();
        test_truncate();
        test_clamp();
        test_start_busy();
        test_cont_en_drop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/tdc_sensor_ctrl.md
Name: tdc_sensor_ctrl

Overview:
- Parametrised, self-timed TDC delay sensor.
- A launch flop drives an edge into a chain of N_TAPS delay taps built from kept cinv cells. The tap outputs are sampled one clk period later, resynchronised, encoded to a tap count and optionally averaged over 2^k samples.
- Used as an on-chip timing/voltage-droop monitor next to the ring-oscillator tiles.
- Replaces the single-ended stop-sampled delay line with a clocked capture FSM, polarity handling, averaging, continuous mode and range flags.

Parameters:
- N_TAPS, 32, number of delay taps (≥4).
- INV_PER_TAP, 12, cinv cells per tap (must be even, ≥2).
- AVG_MAX_LOG2, 4, largest averaging exponent accepted on cfg_avg.
- CNT_W, $clog2(N_TAPS+1), tap-count width (derived, localparam).
- SUM_W, CNT_W+AVG_MAX_LOG2, accumulator width (derived, localparam).

Ports:
- clk  in  1  system clock; also the launch/capture reference.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  block enable; low forces IDLE at the next edge.
- start  in  1  one-cycle pulse; begins a measurement when in IDLE.
- cfg_cont  in  1  1 = restart automatically after each result.
- cfg_avg  in  $clog2(AVG_MAX_LOG2+1)  averaging exponent k (2^k samples); values above AVG_MAX_LOG2 are clamped.
- busy  out  1  high from leaving IDLE until the return to IDLE.
- result  out  CNT_W  averaged tap count (sum >> k).
- result_valid  out  1  one-cycle pulse when result updates.
- raw_snap  out  N_TAPS  last resynchronised snapshot, polarity-normalised.
- ovf  out  1  sticky within a measurement: some sample had all taps reached (line too short).
- unf  out  1  sticky within a measurement: some sample had zero taps reached.

Behaviour:
- Reset values (async, rst_n low):
  - launch_q=0, state IDLE, busy=0, result=0, result_valid=0, raw_snap=0, ovf=0, unf=0.
  - Accumulator and sample counter are 0.
- Delay line:
  - tap[0] input = launch_q.
  - Each tap is INV_PER_TAP cinv cells, so every tap output carries the same polarity as launch_q.
  - Instances and nets carry keep attributes.
- FSM states: IDLE, LAUNCH, CAPT, SYNC, ENC, ACC, DONE.
  - IDLE: if en & start, go to LAUNCH; clear accumulator, sample counter, ovf and unf.
  - LAUNCH: launch_q toggles on the exiting edge; pol_q <= new launch_q value. Next state CAPT.
  - CAPT: the exiting edge samples tap[N_TAPS-1:0] into snap1. The capture window is exactly one clk period after the launch edge.
  - SYNC: snap2 <= snap1 (metastability stage); next ENC.
  - ENC:
    - norm = pol_q ? snap2 : ~snap2; raw_snap <= norm.
    - cnt <= index of the first 0 in norm scanning from bit 0, or N_TAPS if none. This makes the encoder bubble-tolerant: bits above the first 0 are ignored.
  - ACC:
    - acc += cnt; ovf |= (cnt==N_TAPS); unf |= (cnt==0); sample counter increments.
    - If the counter reaches 2^k, go to DONE; else go to LAUNCH.
  - DONE:
    - result <= acc >> k (truncate); result_valid pulses for 1 cycle.
    - If cfg_cont & en, go to LAUNCH and clear acc, counter, ovf and unf in the same edge; else go to IDLE.
- Latency: 5 cycles per sample. With start seen at edge 0, result_valid is high in cycle 5·2^k+1.
- Polarity: launch_q alternates every sample, so successive samples use rising then falling edges. Normalisation makes the results comparable.
- start while busy: ignored.
- en deasserted mid-measurement: the next edge goes to IDLE; no result_valid; result holds its old value; launch_q keeps its level.
- Async reset mid-operation: everything returns to reset values immediately.
- cfg_avg and cfg_cont are sampled on leaving IDLE/DONE and held internally for the measurement.
- Accumulator width SUM_W never overflows: max = N_TAPS·2^AVG_MAX_LOG2.

Decomposition:
- Package tdc_pkg holds:
  - FSM state encoding (3-bit localparams).
  - A clog2-style width helper.
  - A default INV_PER_TAP constant.
- Sub-module tdc_tap: one tap of INV_PER_TAP kept cinv cells in a generate loop (in a, out q). Instantiated N_TAPS times in series.
- Encoder and FSM live in tdc_sensor_ctrl.

Test Plan:
- Behavioural cinv with #10ps, INV_PER_TAP=12 (120ps/tap), clk 2ns, cfg_avg=0, start pulse: result=16 (±1), result_valid at cycle 6, ovf=unf=0, raw_snap=0x0000FFFF.
- Same setup, cfg_avg=3: 8 samples alternating polarity; result=16, result_valid at cycle 41; launch_q ends at its initial level.
- cinv #2ps (24ps/tap) with clk 2ns: cnt=32 every sample; result=32, ovf=1, unf=0.
- cinv #200ps with clk 2ns: result=0, unf=1, ovf=0.
- Force a bubble into snap (norm=0x0000F7FF): cnt=11, result=11.
- cfg_cont=1 yields result_valid pulses every 5·2^k+1 cycles. Dropping en mid-sample gives busy=0 after 1 cycle and no further pulses. rst_n low mid-ACC clears all outputs asynchronously.
